autocomplete_sweeper: RTL

//  Sequences the combinational AutoComplete cell filler across the Trax board held in a single-port board RAM.

---
 rtl/autocomplete_sweeper.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/autocomplete_sweeper.sv
// Walks the active n x m Trax area cell by cell, feeding an external AutoComplete block, writing back forced tiles.
// Optional fill counter: define AUTOCOMPLETE_FILL_COUNT_EN. Empty cell 7 cycles, occupied 3; RAM has no backpressure.
module autocomplete_sweeper #(
    parameter int MAX_ROW    = 20,
    parameter int MAX_COL    = 20,
    parameter int ADDR_W     = 9,
    parameter int MAX_PASSES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [9:0]        n,
    input  logic [9:0]        m,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [4:0]        passes,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_data,
    output logic [2:0]        ac_curr,
    output logic [2:0]        ac_up,
    output logic [2:0]        ac_right,
    output logic [2:0]        ac_down,
    output logic [2:0]        ac_left,
    output logic [9:0]        ac_i,
    output logic [9:0]        ac_j,
    input  logic              ac_changed,
    input  logic [2:0]        ac_out,
    output logic [15:0]       fill_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_C, S_U, S_R, S_D, S_L, S_E, S_W, S_NXT, S_PASS, S_DONE
    } state_t;

    localparam logic [9:0] ROWS = 10'(MAX_ROW);
    localparam logic [9:0] COLS = 10'(MAX_COL);
    localparam logic [4:0] PMAX = 5'(MAX_PASSES);

    state_t     state;
    logic [9:0] n_r, m_r;
    logic       pass_dirty;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [9:0] r, input logic [9:0] c);
        return ADDR_W'(32'(r) * 32'(MAX_COL) + 32'(c));
    endfunction

    logic has_up, has_right, has_down, has_left, last_col, last_row, bad_size;
    assign has_up    = (ac_i != 10'd0);
    assign has_right = ((ac_j + 10'd1) < m_r);
    assign has_down  = ((ac_i + 10'd1) < n_r);
    assign has_left  = (ac_j != 10'd0);
    assign last_col  = (ac_j == m_r - 10'd1);
    assign last_row  = (ac_i == n_r - 10'd1);
    assign bad_size  = (n == 10'd0) || (m == 10'd0) || (n > ROWS) || (m > COLS);

    // Read strobe is a state decode so the up-read can depend on the centre arriving this cycle.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        case (state)
            S_C: begin rd_en = 1'b1; rd_addr = cell_addr(ac_i, ac_j); end
            S_U: if (rd_data == 3'b000 && has_up) begin
                rd_en = 1'b1; rd_addr = cell_addr(ac_i - 10'd1, ac_j);
            end
            S_R: if (has_right) begin rd_en = 1'b1; rd_addr = cell_addr(ac_i, ac_j + 10'd1); end
            S_D: if (has_down)  begin rd_en = 1'b1; rd_addr = cell_addr(ac_i + 10'd1, ac_j); end
            S_L: if (has_left)  begin rd_en = 1'b1; rd_addr = cell_addr(ac_i, ac_j - 10'd1); end
            default: ;
        endcase
    end

    assign wr_en   = (state == S_W) && ac_changed;
    assign wr_addr = wr_en ? cell_addr(ac_i, ac_j) : '0;
    assign wr_data = wr_en ? ac_out : 3'b000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            passes     <= '0;
            n_r        <= '0;
            m_r        <= '0;
            pass_dirty <= 1'b0;
            ac_curr    <= '0;
            ac_up      <= '0;
            ac_right   <= '0;
            ac_down    <= '0;
            ac_left    <= '0;
            ac_i       <= '0;
            ac_j       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    passes <= '0;
                    if (bad_size) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        n_r        <= n;
                        m_r        <= m;
                        busy       <= 1'b1;
                        err        <= 1'b0;
                        pass_dirty <= 1'b0;
                        ac_i       <= '0;
                        ac_j       <= '0;
                        state      <= S_C;
                    end
                end
                S_C: state <= S_U;
                S_U: begin
                    ac_curr <= rd_data;
                    state   <= (rd_data != 3'b000) ? S_NXT : S_R;
                end
                S_R: begin ac_up    <= has_up    ? rd_data : 3'b000; state <= S_D; end
                S_D: begin ac_right <= has_right ? rd_data : 3'b000; state <= S_L; end
                S_L: begin ac_down  <= has_down  ? rd_data : 3'b000; state <= S_E; end
                S_E: begin ac_left  <= has_left  ? rd_data : 3'b000; state <= S_W; end
                // The write cycle also advances, keeping an empty cell at 7 cycles.
                S_W, S_NXT: begin
                    if (state == S_W && ac_changed)
                        pass_dirty <= 1'b1;
                    if (last_col) begin
                        ac_j <= '0;
                        if (last_row) begin
                            state <= S_PASS;
                        end else begin
                            ac_i  <= ac_i + 10'd1;
                            state <= S_C;
                        end
                    end else begin
                        ac_j  <= ac_j + 10'd1;
                        state <= S_C;
                    end
                end
                S_PASS: begin
                    if (passes < PMAX)
                        passes <= passes + 5'd1;
                    if (!pass_dirty || (passes + 5'd1 >= PMAX)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        err   <= pass_dirty;
                        state <= S_DONE;
                    end else begin
                        pass_dirty <= 1'b0;
                        ac_i       <= '0;
                        ac_j       <= '0;
                        state      <= S_C;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef AUTOCOMPLETE_FILL_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            fill_count <= '0;
        else if (state == S_IDLE && start)
            fill_count <= '0;
        else if (wr_en && fill_count != 16'hFFFF)
            fill_count <= fill_count + 16'd1;
    end
`else
    assign fill_count = '0;
`endif

endmodule
